chime_sequencer: RTL and testbench

//  Parametrised hourly/half-hour chime generator for the digital clock.

---
 rtl/chime_pkg.sv | 63 ++++++
 rtl/chime_trigger_det.sv | 87 ++++++++
 rtl/chime_sequencer.sv | 128 ++++++++++++
 tb/tb_chime_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chime_pkg.sv
// chime_pkg: shared state encoding, time constants and the strike-count helper
// for the hourly/half-hour chime.
// Optional feature macro: QUARTER_CHIME_EN (quarter-hour chimes, 4 lead-in strikes on the hour).
package chime_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } chime_state_t;

   localparam logic [5:0] HOURS_PER_DAY      = 6'd24;
   localparam logic [5:0] HOURS_PER_HALF_DAY = 6'd12;
   localparam logic [5:0] HALF_MIN           = 6'd30;
   localparam int         STRIKE_W           = 5;

`ifdef QUARTER_CHIME_EN
   localparam logic [5:0] QUARTER_MIN        = 6'd15;
   localparam logic [5:0] THREE_QUARTER_MIN  = 6'd45;
   localparam logic [STRIKE_W-1:0] MAX_STRIKES     = 5'd16;
   localparam logic [STRIKE_W-1:0] LEAD_IN_STRIKES = 5'd4;
   localparam logic [STRIKE_W-1:0] HALF_STRIKES    = 5'd2;
`else
   localparam logic [STRIKE_W-1:0] MAX_STRIKES     = 5'd12;
   localparam logic [STRIKE_W-1:0] LEAD_IN_STRIKES = 5'd0;
   localparam logic [STRIKE_W-1:0] HALF_STRIKES    = 5'd1;
`endif

   // Number of strikes for a chime boundary; 0 means "no burst".
   // Assumes second==0 has already been decoded by the caller.
   function automatic logic [STRIKE_W-1:0] strike_count(input logic [5:0] hour,
                                                         input logic [5:0] minute,
                                                         input logic       half_ok);
      logic [STRIKE_W-1:0] n;
      logic [STRIKE_W-1:0] h12;
      n   = 5'd0;
      h12 = 5'd0;
      if (hour >= HOURS_PER_DAY) begin
         n = 5'd0;
      end else if (minute == 6'd0) begin
         if (hour == 6'd0) begin
            h12 = 5'd12;
         end else if (hour > HOURS_PER_HALF_DAY) begin
            h12 = 5'(hour - HOURS_PER_HALF_DAY);
         end else begin
            h12 = hour[4:0];
         end
         n = h12 + LEAD_IN_STRIKES;
      end else if (minute == HALF_MIN) begin
         n = half_ok ? HALF_STRIKES : 5'd0;
`ifdef QUARTER_CHIME_EN
      end else if (minute == QUARTER_MIN) begin
         n = 5'd1;
      end else if (minute == THREE_QUARTER_MIN) begin
         n = 5'd3;
`endif
      end else begin
         n = 5'd0;
      end
      return (n > MAX_STRIKES) ? MAX_STRIKES : n;
   endfunction

endpackage

// File: rtl/chime_trigger_det.sv
// chime_trigger_det: decodes chime boundaries, detects the rising edge of a
// match, applies enable and quiet-window suppression and supplies the strike count.
// Optional feature macro: QUARTER_CHIME_EN (also matches :15/:30/:45, half_en ignored).
module chime_trigger_det
   import chime_pkg::*;
#(
   parameter int QUIET_START = 22,
   parameter int QUIET_END   = 7,
   parameter int CNT_W       = 4
) (
   input  logic             clk_1Hz,
   input  logic             rst_n,
   input  logic [5:0]       hour,
   input  logic [5:0]       minute,
   input  logic [5:0]       second,
   input  logic             chime_en,
   input  logic             half_en,
   output logic             trig,
   output logic [CNT_W-1:0] strike_n
);

   localparam logic [5:0] Q_START = 6'(QUIET_START);
   localparam logic [5:0] Q_END   = 6'(QUIET_END);

   logic                half_ok_s;
   logic                match_s;
   logic                match_r;
   logic                quiet_s;
   logic [STRIKE_W-1:0] count_s;

`ifdef QUARTER_CHIME_EN
   // The :30 chime always sounds (2 strikes) when quarter chimes are on.
   logic unused_half_s;
   assign unused_half_s = half_en;
   assign half_ok_s     = 1'b1;
`else
   assign half_ok_s     = half_en;
`endif

   // Decode whether the current time sits on a chime boundary.
   always_comb begin
      match_s = 1'b0;
      if (second != 6'd0) begin
         match_s = 1'b0;
      end else if (minute == 6'd0) begin
         match_s = 1'b1;
      end else if (minute == HALF_MIN) begin
         match_s = half_ok_s;
`ifdef QUARTER_CHIME_EN
      end else if ((minute == QUARTER_MIN) || (minute == THREE_QUARTER_MIN)) begin
         match_s = 1'b1;
`endif
      end else begin
         match_s = 1'b0;
      end
   end

   // Remember last cycle's match so a held boundary time only triggers once.
   always_ff @(posedge clk_1Hz or negedge rst_n) begin
      if (!rst_n) begin
         match_r <= 1'b0;
      end else begin
         match_r <= match_s;
      end
   end

   // Quiet window check; the window wraps midnight when START > END.
   always_comb begin
      quiet_s = 1'b0;
      if (Q_START == Q_END) begin
         quiet_s = 1'b0;
      end else if (Q_START < Q_END) begin
         quiet_s = (hour >= Q_START) && (hour < Q_END);
      end else begin
         quiet_s = (hour >= Q_START) || (hour < Q_END);
      end
   end

   // Strike count and the accepted-trigger strobe for this cycle.
   always_comb begin
      count_s  = strike_count(hour, minute, half_ok_s);
      strike_n = CNT_W'(count_s);
      trig     = match_s & ~match_r & chime_en & ~quiet_s &
                 (count_s != {STRIKE_W{1'b0}});
   end

endmodule

// File: rtl/chime_sequencer.sv
// chime_sequencer: hourly/half-hour chime generator. Holds the strike FSM,
// the tick and strike counters and all registered outputs; trigger decode lives
// in chime_trigger_det.
// Optional feature macro: QUARTER_CHIME_EN (quarter chimes; needs CNT_W >= 5).
module chime_sequencer
   import chime_pkg::*;
#(
   parameter int ON_TICKS    = 1,
   parameter int OFF_TICKS   = 1,
   parameter int QUIET_START = 22,
   parameter int QUIET_END   = 7,
   parameter int CNT_W       = 4
) (
   input  logic             clk_1Hz,
   input  logic             rst_n,
   input  logic [5:0]       hour,
   input  logic [5:0]       minute,
   input  logic [5:0]       second,
   input  logic             chime_en,
   input  logic             half_en,
   output logic             LED,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] strikes_left,
   output logic             missed
);

   localparam int TICK_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int TICK_W   = $clog2(TICK_MAX) + 1;

   localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
   localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
   localparam logic [TICK_W-1:0] ON_LOAD   = TICK_W'(ON_TICKS - 1);
   localparam logic [TICK_W-1:0] OFF_LOAD  = TICK_W'(OFF_TICKS - 1);
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   chime_state_t      state_r;
   logic [TICK_W-1:0] tick_r;
   logic              trig_s;
   logic [CNT_W-1:0]  strike_n_s;

   chime_trigger_det #(
      .QUIET_START (QUIET_START),
      .QUIET_END   (QUIET_END),
      .CNT_W       (CNT_W)
   ) u_trig (
      .clk_1Hz  (clk_1Hz),
      .rst_n    (rst_n),
      .hour     (hour),
      .minute   (minute),
      .second   (second),
      .chime_en (chime_en),
      .half_en  (half_en),
      .trig     (trig_s),
      .strike_n (strike_n_s)
   );

   // Strike FSM: IDLE -> ON -> OFF -> ON ... -> IDLE, all outputs registered.
   always_ff @(posedge clk_1Hz or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         tick_r       <= TICK_ZERO;
         LED          <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         missed       <= 1'b0;
         strikes_left <= CNT_ZERO;
      end else begin
         done   <= 1'b0;
         missed <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (trig_s) begin
                  state_r      <= ST_ON;
                  tick_r       <= ON_LOAD;
                  LED          <= 1'b1;
                  busy         <= 1'b1;
                  strikes_left <= strike_n_s;
               end else begin
                  tick_r       <= TICK_ZERO;
                  LED          <= 1'b0;
                  busy         <= 1'b0;
                  strikes_left <= CNT_ZERO;
               end
            end
            ST_ON: begin
               // A trigger during a burst is dropped but reported.
               missed <= trig_s;
               if (tick_r == TICK_ZERO) begin
                  state_r <= ST_OFF;
                  tick_r  <= OFF_LOAD;
                  LED     <= 1'b0;
               end else begin
                  tick_r  <= tick_r - TICK_ONE;
               end
            end
            ST_OFF: begin
               missed <= trig_s;
               if (tick_r == TICK_ZERO) begin
                  if (strikes_left == CNT_ONE) begin
                     state_r      <= ST_IDLE;
                     tick_r       <= TICK_ZERO;
                     busy         <= 1'b0;
                     done         <= 1'b1;
                     strikes_left <= CNT_ZERO;
                  end else begin
                     state_r      <= ST_ON;
                     tick_r       <= ON_LOAD;
                     LED          <= 1'b1;
                     strikes_left <= strikes_left - CNT_ONE;
                  end
               end else begin
                  tick_r <= tick_r - TICK_ONE;
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               tick_r       <= TICK_ZERO;
               LED          <= 1'b0;
               busy         <= 1'b0;
               strikes_left <= CNT_ZERO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chime_sequencer.sv
// tb_chime_sequencer: bench for chime_sequencer. Two instances share the inputs:
// dut_a uses default timing and the 22..7 quiet window, dut_b uses 2/3 tick timing
// and no quiet window. Honours QUARTER_CHIME_EN when defined.
`timescale 1ns/1ps
module tb_chime_sequencer;

`ifdef QUARTER_CHIME_EN
   localparam int CW = 5;
`else
   localparam int CW = 4;
`endif

   logic          clk_1Hz = 1'b0;
   logic          rst_n;
   logic [5:0]    hour, minute, second;
   logic          chime_en, half_en;
   logic          led_a, busy_a, done_a, missed_a;
   logic [CW-1:0] left_a;
   logic          led_b, busy_b, done_b, missed_b;
   logic [CW-1:0] left_b;

   always #5 clk_1Hz = ~clk_1Hz;

   chime_sequencer #(.CNT_W(CW)) dut_a (
      .clk_1Hz(clk_1Hz), .rst_n(rst_n), .hour(hour), .minute(minute), .second(second),
      .chime_en(chime_en), .half_en(half_en), .LED(led_a), .busy(busy_a), .done(done_a),
      .strikes_left(left_a), .missed(missed_a));

   chime_sequencer #(.ON_TICKS(2), .OFF_TICKS(3), .QUIET_START(5), .QUIET_END(5), .CNT_W(CW)) dut_b (
      .clk_1Hz(clk_1Hz), .rst_n(rst_n), .hour(hour), .minute(minute), .second(second),
      .chime_en(chime_en), .half_en(half_en), .LED(led_b), .busy(busy_b), .done(done_b),
      .strikes_left(left_b), .missed(missed_b));

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: per instance, cycles elapsed since a burst was accepted.
   int p_on[2]  = '{1, 2};
   int p_off[2] = '{1, 3};
   int p_qs[2]  = '{22, 5};
   int p_qe[2]  = '{7, 5};
   int m_e[2];
   int m_n[2];
   bit m_lm[2];
   bit m_done[2];
   bit m_missed[2];

   typedef struct {
      int hr; int mn; bit half; bit en;
      int want_a; int want_b; int want_qa; int want_qb;
   } scen_t;
   typedef struct { bit led; bit busy; bit done; int left; } seq_t;

   scen_t scen[14];
   seq_t  sq[6];
   int    sq_len;
   int    mins[6] = '{0, 15, 30, 45, 0, 59};

   task automatic chk(input string name, input int act, input int want);
      n_total++;
      if (act == want) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
   endtask

   function automatic bit mdl_match(int m, int s, bit half);
      if (s != 0) return 1'b0;
`ifdef QUARTER_CHIME_EN
      return (m == 0) || (m == 15) || (m == 30) || (m == 45);
`else
      return (m == 0) || (half && (m == 30));
`endif
   endfunction

   function automatic int mdl_n(int h, int m, bit half);
      int h12;
      if (h > 23) return 0;
      h12 = (h % 12 == 0) ? 12 : h % 12;
`ifdef QUARTER_CHIME_EN
      if (m == 0) return h12 + 4;
      if (m == 15 || m == 30 || m == 45) return m / 15;
`else
      if (m == 0) return h12;
      if (m == 30 && half) return 1;
`endif
      return 0;
   endfunction

   function automatic bit mdl_quiet(int k, int h);
      int s = p_qs[k];
      int e = p_qe[k];
      if (s == e) return 1'b0;
      return ((h - s + 24) % 24) < ((e - s + 24) % 24);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_e[k] = 0; m_n[k] = 0; m_lm[k] = 1'b0; m_done[k] = 1'b0; m_missed[k] = 1'b0;
      end
   endtask

   task automatic model_edge();
      bit mt; int nn; bit go; int per;
      mt = mdl_match(int'(minute), int'(second), half_en);
      nn = mdl_n(int'(hour), int'(minute), half_en);
      for (int k = 0; k < 2; k++) begin
         m_done[k] = 1'b0;
         m_missed[k] = 1'b0;
         if (!rst_n) begin
            m_e[k] = 0; m_n[k] = 0; m_lm[k] = 1'b0;
         end else begin
            go = mt && !m_lm[k] && chime_en && (nn > 0) && !mdl_quiet(k, int'(hour));
            m_lm[k] = mt;
            per = p_on[k] + p_off[k];
            if (m_e[k] >= 1 && m_e[k] <= m_n[k] * per) begin
               m_missed[k] = go;
               m_e[k]++;
               if (m_e[k] == m_n[k] * per + 1) m_done[k] = 1'b1;
            end else if (go) begin
               m_e[k] = 1; m_n[k] = nn;
            end else begin
               m_e[k] = 0;
            end
         end
      end
   endtask

   function automatic int exp_vec(int k);
      int per = p_on[k] + p_off[k];
      bit b;
      int led = 0;
      int left = 0;
      b = (m_e[k] >= 1) && (m_e[k] <= m_n[k] * per);
      if (b) begin
         led  = (((m_e[k] - 1) % per) < p_on[k]) ? 1 : 0;
         left = m_n[k] - (m_e[k] - 1) / per;
      end
      return (led << 11) | (int'(b) << 10) | (int'(m_done[k]) << 9) | (int'(m_missed[k]) << 8) | left;
   endfunction

   function automatic int act_vec(int k);
      if (k == 0) return int'({led_a, busy_a, done_a, missed_a, 8'(left_a)});
      return int'({led_b, busy_b, done_b, missed_b, 8'(left_b)});
   endfunction

   task automatic step();
      @(posedge clk_1Hz);
      model_edge();
      @(negedge clk_1Hz);
      chk("cycle_a", act_vec(0), exp_vec(0));
      chk("cycle_b", act_vec(1), exp_vec(1));
   endtask

   task automatic set_time(input int h, input int m, input int s);
      hour = 6'(h); minute = 6'(m); second = 6'(s);
   endtask

   task automatic wait_idle();
      int guard = 0;
      while ((busy_a || busy_b) && guard < 300) begin
         step();
         guard++;
      end
      if (guard >= 300) begin
         n_total++;
         $display("FAIL idle_timeout: busy_a=%0b busy_b=%0b after %0d cycles", busy_a, busy_b, guard);
      end
      step();
   endtask

   initial begin
      int cnt_a, cnt_b, guard, want;
      bit prev_a, prev_b;

      scen[0]  = '{14, 0,  1'b0, 1'b1, 2,  2,  6,  6};
      scen[1]  = '{0,  0,  1'b0, 1'b1, 0,  12, 0,  16};
      scen[2]  = '{12, 0,  1'b0, 1'b1, 12, 12, 16, 16};
      scen[3]  = '{25, 0,  1'b0, 1'b1, 0,  0,  0,  0};
      scen[4]  = '{9,  30, 1'b1, 1'b1, 1,  1,  2,  2};
      scen[5]  = '{9,  30, 1'b0, 1'b1, 0,  0,  2,  2};
      scen[6]  = '{23, 0,  1'b0, 1'b1, 0,  11, 0,  15};
      scen[7]  = '{6,  0,  1'b0, 1'b1, 0,  6,  0,  10};
      scen[8]  = '{7,  0,  1'b0, 1'b1, 7,  7,  11, 11};
      scen[9]  = '{13, 0,  1'b0, 1'b0, 0,  0,  0,  0};
      scen[10] = '{22, 30, 1'b1, 1'b1, 0,  1,  0,  2};
      scen[11] = '{3,  0,  1'b0, 1'b1, 0,  3,  0,  7};
      scen[12] = '{3,  45, 1'b0, 1'b1, 0,  0,  0,  3};
      scen[13] = '{21, 0,  1'b0, 1'b1, 9,  9,  13, 13};

      // Reset values
      rst_n = 1'b0; chime_en = 1'b1; half_en = 1'b0;
      set_time(12, 34, 56);
      model_reset();
      #3;
      step();
      chk("reset_a", act_vec(0), 0);
      chk("reset_b", act_vec(1), 0);
      step();
      rst_n = 1'b1;
      step();

      // Cycle-exact first burst on dut_a
`ifdef QUARTER_CHIME_EN
      sq[0] = '{1'b1, 1'b1, 1'b0, 1}; sq[1] = '{1'b0, 1'b1, 1'b0, 1};
      sq[2] = '{1'b0, 1'b0, 1'b1, 0}; sq[3] = '{1'b0, 1'b0, 1'b0, 0};
      sq_len = 4;
      set_time(14, 14, 59);
`else
      sq[0] = '{1'b1, 1'b1, 1'b0, 2}; sq[1] = '{1'b0, 1'b1, 1'b0, 2};
      sq[2] = '{1'b1, 1'b1, 1'b0, 1}; sq[3] = '{1'b0, 1'b1, 1'b0, 1};
      sq[4] = '{1'b0, 1'b0, 1'b1, 0}; sq[5] = '{1'b0, 1'b0, 1'b0, 0};
      sq_len = 6;
      set_time(13, 59, 59);
`endif
      step();
      chk("pre_idle", int'({led_a, busy_a, done_a}), 0);
`ifdef QUARTER_CHIME_EN
      set_time(14, 15, 0);
`else
      set_time(14, 0, 0);
`endif
      for (int k = 0; k < sq_len; k++) begin
         step();
         if (k == 0) second = 6'd1;
         want = (int'(sq[k].led) << 10) | (int'(sq[k].busy) << 9) | (int'(sq[k].done) << 8) | sq[k].left;
         chk($sformatf("first_seq[%0d]", k), int'({led_a, busy_a, done_a, 8'(left_a)}), want);
      end

      // Scenario table: strike counts per trigger
      for (int i = 0; i < 14; i++) begin
         wait_idle();
         chime_en = scen[i].en;
         half_en  = scen[i].half;
         set_time(scen[i].hr, scen[i].mn, 59);
         step();
         step();
         second = 6'd0;
         step();
         second = 6'd1;
         cnt_a = 0; cnt_b = 0; prev_a = 1'b0; prev_b = 1'b0; guard = 0;
         if (led_a && !prev_a) cnt_a++;
         if (led_b && !prev_b) cnt_b++;
         prev_a = led_a; prev_b = led_b;
         while ((busy_a || busy_b) && guard < 300) begin
            step();
            guard++;
            if (led_a && !prev_a) cnt_a++;
            if (led_b && !prev_b) cnt_b++;
            prev_a = led_a; prev_b = led_b;
         end
         if (guard >= 300) begin
            n_total++;
            $display("FAIL burst_timeout[%0d]: still busy after %0d cycles", i, guard);
         end
`ifdef QUARTER_CHIME_EN
         chk($sformatf("count_a[%0d]", i), cnt_a, scen[i].want_qa);
         chk($sformatf("count_b[%0d]", i), cnt_b, scen[i].want_qb);
`else
         chk($sformatf("count_a[%0d]", i), cnt_a, scen[i].want_a);
         chk($sformatf("count_b[%0d]", i), cnt_b, scen[i].want_b);
`endif
      end

      // Held trigger gives one burst; a trigger while busy reports missed
      wait_idle();
      chime_en = 1'b1; half_en = 1'b1;
      set_time(10, 0, 0);
      cnt_a = 0; cnt_b = 0; prev_a = 1'b0; prev_b = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k == 3) set_time(10, 0, 1);
         if (k == 4) set_time(10, 30, 0);
         step();
         if (busy_a && !prev_a) cnt_a++;
         if (busy_b && !prev_b) cnt_b++;
         prev_a = busy_a; prev_b = busy_b;
      end
      chk("missed_a", int'(missed_a), 1);
      chk("missed_b", int'(missed_b), 1);
`ifdef QUARTER_CHIME_EN
      chk("left_after_missed", int'(left_a), 12);
`else
      chk("left_after_missed", int'(left_a), 8);
`endif
      set_time(10, 30, 1);
      guard = 0;
      while ((busy_a || busy_b) && guard < 300) begin
         step();
         guard++;
         if (busy_a && !prev_a) cnt_a++;
         if (busy_b && !prev_b) cnt_b++;
         prev_a = busy_a; prev_b = busy_b;
      end
      chk("hold_bursts_a", cnt_a, 1);
      chk("hold_bursts_b", cnt_b, 1);

      // Reset in the middle of a burst
      wait_idle();
      set_time(8, 0, 0);
      step();
      second = 6'd1;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_a", int'({led_a, busy_a, 8'(left_a)}), 0);
      chk("rst_async_b", int'({led_b, busy_b, 8'(left_b)}), 0);
      model_reset();
      step();
      chk("rst_no_done", int'({done_a, done_b}), 0);
      step();
      rst_n = 1'b1;
      step();
      step();
      chk("post_rst_idle", int'({busy_a, busy_b, done_a, done_b}), 0);

      // Randomised traffic against the model
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 3) == 0) hour = 6'($urandom_range(0, 25));
         if ($urandom_range(0, 2) == 0) minute = 6'(mins[$urandom_range(0, 5)]);
         second   = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'd59;
         chime_en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 15) == 0) half_en = ~half_en;
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
